// File: rtl/pma_lookup_arbiter.sv
// PMA rule table with a shared round-robin lookup engine.
// One rule slot per cycle is scanned for all three attribute classes.
package ariane_cfg_pkg;
  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                       NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]       NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]       NonIdempotentLength;
    int unsigned                       NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]       ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]       ExecuteRegionLength;
    int unsigned                       NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]       CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]       CachedRegionLength;
  } ariane_cfg_t;

  // DRAM, boot ROM and debug module regions
  localparam ariane_cfg_t ArianeDefaultConfig = '{
    NrNonIdempotentRules:  2,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0,
    NrExecuteRegionRules:  3,
    ExecuteRegionAddrBase: '{0: 64'h8000_0000, 1: 64'h1_0000,
                             default: 64'h0},
    ExecuteRegionLength:   '{0: 64'h4000_0000, 1: 64'h1_0000,
                             2: 64'h1000, default: 64'h0},
    NrCachedRegionRules:   1,
    CachedRegionAddrBase:  '{0: 64'h8000_0000, default: 64'h0},
    CachedRegionLength:    '{0: 64'h4000_0000, default: 64'h0}
  };
endpackage

module pma_lookup_arbiter
  import ariane_cfg_pkg::*;
#(
  parameter ariane_cfg_t Cfg     = ArianeDefaultConfig,
  parameter int unsigned NrRules = 4,
  parameter int unsigned NrReq   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NrReq-1:0]      req_valid_i,
  output logic [NrReq-1:0]      req_ready_o,
  input  logic [NrReq*64-1:0]   req_addr_i,
  output logic [NrReq-1:0]      rsp_valid_o,
  output logic [2:0]            rsp_attr_o,
  input  logic                  cfg_we_i,
  input  logic [1:0]            cfg_class_i,
  input  logic [3:0]            cfg_idx_i,
  input  logic [63:0]           cfg_base_i,
  input  logic [63:0]           cfg_len_i,
  input  logic                  cfg_en_i,
  output logic                  cfg_ready_o,
  output logic                  cfg_err_o,
  output logic                  busy_o
);

  localparam int unsigned RrW = (NrReq > 1) ? $clog2(NrReq) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [63:0]    addr_q, addr_d;
  logic [RrW-1:0] own_q, own_d;
  logic [RrW-1:0] rr_q, rr_d;
  logic [2:0]     hit_q, hit_d;
  logic           err_q, err_d;

  // class index: 0 = non-idempotent, 1 = execute, 2 = cached
  logic [63:0]    base_q [3][NrRules];
  logic [63:0]    len_q  [3][NrRules];
  logic           en_q   [3][NrRules];

  logic [63:0]    cur_base [3];
  logic [63:0]    cur_len  [3];
  logic           cur_en   [3];
  logic [2:0]     hit_now;
  logic           gnt_vld;
  logic [RrW-1:0] gnt_id;
  logic [63:0]    gnt_addr;
  logic           cfg_acc;
  logic           cfg_bad;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      cur_base[c] = '0;
      cur_len[c]  = '0;
      cur_en[c]   = 1'b0;
      for (int k = 0; k < int'(NrRules); k++) begin
        if (idx_q == 4'(k)) begin
          cur_base[c] = base_q[c][k];
          cur_len[c]  = len_q[c][k];
          cur_en[c]   = en_q[c][k];
        end
      end
      // 65-bit limit so a region ending at 2^64 still covers the top
      hit_now[c] = cur_en[c]
        && ({1'b0, addr_q} >= {1'b0, cur_base[c]})
        && ({1'b0, addr_q} < ({1'b0, cur_base[c]} + {1'b0, cur_len[c]}));
    end
  end

  always_comb begin
    int j;
    j        = 0;
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    gnt_addr = '0;
    for (int i = int'(NrReq) - 1; i >= 0; i--) begin
      j = (int'(rr_q) + i) % int'(NrReq);
      if (req_valid_i[j]) begin
        gnt_vld  = 1'b1;
        gnt_id   = RrW'(j);
        gnt_addr = req_addr_i[j*64 +: 64];
      end
    end
  end

  assign cfg_ready_o = (state_q == IDLE) && rst_ni;
  assign cfg_acc     = cfg_ready_o && cfg_we_i;
  assign cfg_bad     = (cfg_class_i == 2'd3)
                    || ({1'b0, cfg_idx_i} >= 5'(NrRules));

  always_comb begin
    req_ready_o = '0;
    if (cfg_ready_o && !cfg_we_i && gnt_vld)
      req_ready_o = NrReq'(1) << gnt_id;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    own_d   = own_q;
    rr_d    = rr_q;
    hit_d   = hit_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_acc) begin
          err_d = cfg_bad;
        end else if (|req_ready_o) begin
          addr_d  = gnt_addr;
          own_d   = gnt_id;
          hit_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        hit_d = hit_q | hit_now;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(NrRules - 1))
          state_d = RESP;
      end
      RESP: begin
        rr_d    = (own_q == RrW'(NrReq - 1)) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      hit_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < int'(NrRules); k++) begin
        base_q[0][k] <= Cfg.NonIdempotentAddrBase[k[3:0]];
        len_q[0][k]  <= Cfg.NonIdempotentLength[k[3:0]];
        en_q[0][k]   <= k < int'(Cfg.NrNonIdempotentRules);
        base_q[1][k] <= Cfg.ExecuteRegionAddrBase[k[3:0]];
        len_q[1][k]  <= Cfg.ExecuteRegionLength[k[3:0]];
        en_q[1][k]   <= k < int'(Cfg.NrExecuteRegionRules);
        base_q[2][k] <= Cfg.CachedRegionAddrBase[k[3:0]];
        len_q[2][k]  <= Cfg.CachedRegionLength[k[3:0]];
        en_q[2][k]   <= k < int'(Cfg.NrCachedRegionRules);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < int'(NrRules); k++) begin
          if (cfg_acc && !cfg_bad && cfg_class_i == 2'(c)
              && cfg_idx_i == 4'(k)) begin
            base_q[c][k] <= cfg_base_i;
            len_q[c][k]  <= cfg_len_i;
            en_q[c][k]   <= cfg_en_i;
          end
        end
      end
    end
  end

  assign rsp_valid_o = (state_q == RESP) ? (NrReq'(1) << own_q) : '0;
  assign rsp_attr_o  = (state_q == RESP) ? {hit_q[0], hit_q[2], hit_q[1]}
                                         : 3'b000;
  assign cfg_err_o   = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_pma_lookup_arbiter.sv
// Directed bench for pma_lookup_arbiter: vector table plus
// hand-written round-robin, collision, error and reset sequences.
module tb_pma_lookup_arbiter;
  localparam int NR = 4;
  localparam int NQ = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NQ-1:0]     req_valid;
  logic [NQ-1:0]     req_ready;
  logic [NQ*64-1:0]  req_addr;
  logic [NQ-1:0]     rsp_valid;
  logic [2:0]        rsp_attr;
  logic              cfg_we;
  logic [1:0]        cfg_class;
  logic [3:0]        cfg_idx;
  logic [63:0]       cfg_base;
  logic [63:0]       cfg_len;
  logic              cfg_en;
  logic              cfg_ready;
  logic              cfg_err;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pma_lookup_arbiter #(.NrRules(NR), .NrReq(NQ)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .rsp_valid_o (rsp_valid),
    .rsp_attr_o  (rsp_attr),
    .cfg_we_i    (cfg_we),
    .cfg_class_i (cfg_class),
    .cfg_idx_i   (cfg_idx),
    .cfg_base_i  (cfg_base),
    .cfg_len_i   (cfg_len),
    .cfg_en_i    (cfg_en),
    .cfg_ready_o (cfg_ready),
    .cfg_err_o   (cfg_err),
    .busy_o      (busy)
  );

  typedef struct {
    int          r;
    logic [63:0] a;
    logic [2:0]  e;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic lookup(input int r, input logic [63:0] a,
                        input logic [2:0] ea, input string nm,
                        output int waited);
    int w;
    int cnt;
    req_valid[r]         = 1'b1;
    req_addr[r*64 +: 64] = a;
    w = 0;
    #1;
    while (!req_ready[r] && w < 20) begin
      tick;
      w++;
    end
    waited = w;
    if (!req_ready[r]) begin
      chk({nm, " grant timeout"}, 64'(w), 64'(0));
      req_valid[r] = 1'b0;
    end else begin
      tick;
      req_valid[r]         = 1'b0;
      req_addr[r*64 +: 64] = '1;
      cnt = 1;
      while (rsp_valid == '0 && cnt < 20) begin
        tick;
        cnt++;
      end
      chk({nm, " latency"}, 64'(cnt), 64'(NR + 1));
      chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(1 << r));
      chk({nm, " attr"}, 64'(rsp_attr), 64'(ea));
      tick;
    end
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [3:0] i,
                           input logic [63:0] b, input logic [63:0] l,
                           input logic e);
    cfg_we    = 1'b1;
    cfg_class = c;
    cfg_idx   = i;
    cfg_base  = b;
    cfg_len   = l;
    cfg_en    = e;
    #1;
    chk("cfg_ready", 64'(cfg_ready), 64'(1));
    tick;
    cfg_we = 1'b0;
  endtask

  initial begin
    vec_t vt[8];
    int   w;
    int   gcnt;
    int   last;
    int   gid[4];
    int   gcyc[4];
    logic [NQ-1:0] seen;

    vt[0] = '{0, 64'h8000_1000, 3'b011};
    vt[1] = '{0, 64'h0001_0004, 3'b001};
    vt[2] = '{0, 64'h2000_0000, 3'b000};
    vt[3] = '{0, 64'hBFFF_FFFF, 3'b011};
    vt[4] = '{0, 64'hC000_0000, 3'b000};
    vt[5] = '{1, 64'h8000_0000, 3'b011};
    vt[6] = '{1, 64'h0000_0FFF, 3'b001};
    vt[7] = '{1, 64'h0000_1000, 3'b000};

    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    cfg_we    = 1'b0;
    cfg_class = '0;
    cfg_idx   = '0;
    cfg_base  = '0;
    cfg_len   = '0;
    cfg_en    = 1'b0;
    tick;
    tick;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset cfg_err", 64'(cfg_err), 64'(0));
    chk("reset cfg_ready", 64'(cfg_ready), 64'(0));
    chk("reset req_ready", 64'(req_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("idle cfg_ready", 64'(cfg_ready), 64'(1));

    for (int i = 0; i < 8; i++) begin
      lookup(vt[i].r, vt[i].a, vt[i].e, $sformatf("vec%0d", i), w);
      chk($sformatf("vec%0d wait", i), 64'(w), 64'(0));
    end

    // round-robin with both requesters held valid
    do_reset;
    for (int i = 0; i < 4; i++) begin
      gid[i]  = -1;
      gcyc[i] = -1;
    end
    gcnt = 0;
    last = -1;
    req_addr[0 +: 64]  = 64'h8000_0000;
    req_addr[64 +: 64] = 64'h0001_0000;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 60 && gcnt < 4; c++) begin
      if (rsp_valid != '0) begin
        chk("rr rsp owner", 64'(rsp_valid), 64'(1 << last));
        chk("rr rsp attr", 64'(rsp_attr),
            (last == 0) ? 64'(3'b011) : 64'(3'b001));
      end
      if (req_ready != '0) begin
        gid[gcnt]  = req_ready[1] ? 1 : 0;
        gcyc[gcnt] = c;
        last       = gid[gcnt];
        gcnt++;
      end
      tick;
    end
    req_valid = '0;
    chk("rr grant count", 64'(gcnt), 64'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr grant%0d id", i), 64'(gid[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++)
      chk($sformatf("rr gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'(6));
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      seen |= rsp_valid;
      tick;
    end
    chk("rr last rsp owner", 64'(seen), 64'(2'b10));
    chk("rr idle busy", 64'(busy), 64'(0));

    // programmed non-idempotent window
    cfg_write(2'd0, 4'd1, 64'h1000_0000, 64'h1000, 1'b1);
    chk("cfg legal err", 64'(cfg_err), 64'(0));
    lookup(0, 64'h1000_0FFF, 3'b100, "ni inside", w);
    lookup(1, 64'h1000_1000, 3'b000, "ni end", w);

    // write and request in the same IDLE cycle
    cfg_we    = 1'b1;
    cfg_class = 2'd1;
    cfg_idx   = 4'd3;
    cfg_base  = 64'h5000_0000;
    cfg_len   = 64'h100;
    cfg_en    = 1'b1;
    req_valid[0]      = 1'b1;
    req_addr[0 +: 64] = 64'h5000_0080;
    #1;
    chk("coll req_ready", 64'(req_ready), 64'(0));
    chk("coll cfg_ready", 64'(cfg_ready), 64'(1));
    tick;
    cfg_we = 1'b0;
    lookup(0, 64'h5000_0080, 3'b001, "coll lookup", w);
    chk("coll wait", 64'(w), 64'(0));

    // illegal writes leave the table alone
    cfg_write(2'd3, 4'd0, 64'h0, 64'hFFFF_FFFF, 1'b1);
    chk("ill class err", 64'(cfg_err), 64'(1));
    tick;
    chk("ill class err pulse", 64'(cfg_err), 64'(0));
    cfg_write(2'd1, 4'd5, 64'h2000_0000, 64'h1000, 1'b1);
    chk("ill idx err", 64'(cfg_err), 64'(1));
    tick;
    chk("ill idx err pulse", 64'(cfg_err), 64'(0));
    lookup(0, 64'h2000_0000, 3'b000, "ill lookup", w);
    lookup(1, 64'h0001_0000, 3'b001, "ill rom", w);

    // top-of-space, zero length and overlap
    cfg_write(2'd1, 4'd2, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 1'b1);
    lookup(0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, "top", w);
    lookup(1, 64'hFFFF_FFFF_FFFF_EFFF, 3'b000, "below top", w);
    cfg_write(2'd2, 4'd1, 64'h2000_0000, 64'h0, 1'b1);
    lookup(0, 64'h2000_0000, 3'b000, "len0", w);
    cfg_write(2'd0, 4'd0, 64'h8000_0000, 64'h10, 1'b1);
    lookup(1, 64'h8000_0008, 3'b111, "overlap", w);

    // reset during SCAN drops the request and restores defaults
    req_valid[0]      = 1'b1;
    req_addr[0 +: 64] = 64'h8000_0000;
    #1;
    chk("mid grant", 64'(req_ready), 64'(2'b01));
    tick;
    req_valid = '0;
    tick;
    chk("mid busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid rst busy", 64'(busy), 64'(0));
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      seen |= rsp_valid;
      tick;
    end
    chk("mid no rsp", 64'(seen), 64'(0));
    lookup(0, 64'h0, 3'b001, "dflt debug", w);
    lookup(0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, "dflt top", w);
    lookup(1, 64'h1000_0000, 3'b000, "dflt ni", w);
    lookup(1, 64'h5000_0080, 3'b000, "dflt idx3", w);
    lookup(0, 64'h8000_0008, 3'b011, "dflt dram", w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
